// File: rtl/uart_rx_oversampled_if.sv
// CPU-side view of the UART receiver: RX FIFO pop port plus status and sticky error flags.
// master = register logic that pops bytes; slave = the receiver itself.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          err_clr;
  logic [7:0]    rd_data;
  logic          rx_valid;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          frame_err;
  logic          overrun_err;

  modport master (
    output rd_en, err_clr,
    input  rd_data, rx_valid, fifo_count, busy, frame_err, overrun_err
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, rx_valid, fifo_count, busy, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled, with a show-ahead RX FIFO and sticky framing/overrun flags.
// A held-low line after a bad stop bit parks in BRK so it cannot produce a stream of frames.
module uart_rx_oversampled #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  uart_rx_if.slave         bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state;
  logic             rx_m, rx_s;
  logic [DIV_W-1:0] div_cnt, div_lat;
  logic             tick;
  logic [3:0]       sub;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop_pt, push, frame_set, ovr_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, pop, wr;
  logic             frame_err, overrun_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // >= rather than == so a smaller baud_div latched mid-count cannot strand the counter.
  assign tick = rx_en && (div_cnt >= div_lat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else begin
      if (state == IDLE) div_lat <= baud_div;
      if (!rx_en || tick) div_cnt <= '0;
      else                div_cnt <= div_cnt + 1'b1;
    end
  end

  assign stop_pt   = tick && (state == STOP) && (sub == 4'd15);
  assign push      = stop_pt && rx_s;
  assign frame_set = stop_pt && !rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sub     <= '0;
      bit_idx <= '0;
    end else if (!rx_en) begin
      state   <= IDLE;
      sub     <= '0;
      bit_idx <= '0;
    end else if (tick) begin
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          sub   <= '0;
        end
        START: if (sub == 4'd7) begin
          if (!rx_s) begin
            state   <= DATA;
            sub     <= '0;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end else begin
          sub <= sub + 1'b1;
        end
        DATA: if (sub == 4'd15) begin
          shreg <= {rx_s, shreg[7:1]};
          sub   <= '0;
          if (bit_idx == 3'd7) state   <= STOP;
          else                 bit_idx <= bit_idx + 1'b1;
        end else begin
          sub <= sub + 1'b1;
        end
        STOP: if (sub == 4'd15) begin
          sub   <= '0;
          state <= rx_s ? IDLE : BRK;
        end else begin
          sub <= sub + 1'b1;
        end
        BRK:     if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = bus.rd_en && (count != '0);
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_set)        frame_err <= 1'b1;
      else if (bus.err_clr) frame_err <= 1'b0;
      if (ovr_set)          overrun_err <= 1'b1;
      else if (bus.err_clr) overrun_err <= 1'b0;
    end
  end

  assign bus.rd_data     = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.rx_valid    = (count != '0);
  assign bus.fifo_count  = count;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_err   = frame_err;
  assign bus.overrun_err = overrun_err;
endmodule
